// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller slice.
// Holds the CP0 register indices, the exception code constants reported on
// exc_o, the default exception handler entry address, the controller state
// encoding and the interrupt-pending helper.
package exc_ctrl_pkg;

    // CP0 register indices (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    // Exception codes handed to CP0; zero means "no exception"
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_e;

    // An interrupt is pending when an unmasked cause bit is set, interrupts
    // are globally enabled (IE) and the core is not already at exception
    // level (EXL).
    function automatic logic irq_pending(input logic [31:0] status,
                                         input logic [31:0] cause);
        return ((cause[15:8] & status[15:8]) != 8'h00) && status[0] && !status[1];
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Exception priority encoder.
// Ports:
//   irq, ri, syscall, eret : already-qualified event flags
//   code                   : 32-bit exception code of the highest-priority
//                            flag, EXC_NONE when no flag is set
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        irq,
    input  logic        ri,
    input  logic        syscall,
    input  logic        eret,
    output logic [31:0] code
);

    always_comb begin
        code = EXC_NONE;
        if (irq) begin
            code = EXC_INT;
        end else if (ri) begin
            code = EXC_RI;
        end else if (syscall) begin
            code = EXC_SYSCALL;
        end else if (eret) begin
            code = EXC_ERET;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller.
// Watches the memory-stage instruction, picks the highest-priority exception,
// reports it to CP0 for one cycle, flushes the pipeline for FLUSH_CYCLES
// cycles and then redirects fetch to the handler (or to EPC for eret).
// Ports:
//   clk, rst (async, active-low)
//   mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_syscall_i, mem_ri_i,
//   mem_eret_i                       : memory-stage instruction info
//   cp0_status_i, cp0_cause_i, cp0_epc_i : current CP0 values
//   exc_o, exc_pc_o, exc_delayslot_o : one-cycle exception report to CP0
//   flush_o, stall_o                 : pipeline flush / freeze
//   redirect_valid_o, redirect_pc_o, redirect_ready_i : fetch redirect
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_syscall_i,
    input  logic        mem_ri_i,
    input  logic        mem_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] exc_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES);

    logic        irq;
    logic [31:0] code;
    logic        take;
    exc_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exc_q, exc_pc_q, target_q;
    logic        exc_ds_q;

    // Every event source is gated by the instruction valid
    assign irq = mem_valid_i & irq_pending(cp0_status_i, cp0_cause_i);

    exc_prio_enc u_prio (
        .irq     (irq),
        .ri      (mem_valid_i & mem_ri_i),
        .syscall (mem_valid_i & mem_syscall_i),
        .eret    (mem_valid_i & mem_eret_i),
        .code    (code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        take             = 1'b0;
        flush_o          = 1'b0;
        stall_o          = 1'b1;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        unique case (state_q)
            IDLE: begin
                stall_o = 1'b0;
                if (code != EXC_NONE) begin
                    take    = 1'b1;
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                // cnt_q holds the number of flush cycles still to go,
                // including the current one
                if (cnt_q <= 4'd1) begin
                    state_d = REDIRECT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                stall_o = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // The CP0 report is a single-cycle pulse: it is reloaded with zero on
    // every edge that does not accept an event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_q    <= EXC_NONE;
            exc_pc_q <= 32'h0;
            exc_ds_q <= 1'b0;
            target_q <= 32'h0;
        end else begin
            exc_q    <= take ? code : EXC_NONE;
            exc_pc_q <= take ? mem_pc_i : 32'h0;
            exc_ds_q <= take & mem_in_delayslot_i;
            if (take) begin
                target_q <= (code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end
        end
    end

    assign exc_o           = exc_q;
    assign exc_pc_o        = exc_pc_q;
    assign exc_delayslot_o = exc_ds_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl. Expected CP0 reports are queued when an
// event is driven and popped by a monitor whenever exc_o pulses; each test
// task checks flush/stall/redirect behaviour inline.
module tb_exc_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_in_delayslot_i;
    logic        mem_syscall_i, mem_ri_i, mem_eret_i;
    logic [31:0] mem_pc_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic [31:0] exc_o, exc_pc_o, redirect_pc_o;
    logic        exc_delayslot_o, flush_o, stall_o;
    logic        redirect_valid_o, redirect_ready_i;

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_valid_i        (mem_valid_i),
        .mem_pc_i           (mem_pc_i),
        .mem_in_delayslot_i (mem_in_delayslot_i),
        .mem_syscall_i      (mem_syscall_i),
        .mem_ri_i           (mem_ri_i),
        .mem_eret_i         (mem_eret_i),
        .cp0_status_i       (cp0_status_i),
        .cp0_cause_i        (cp0_cause_i),
        .cp0_epc_i          (cp0_epc_i),
        .exc_o              (exc_o),
        .exc_pc_o           (exc_pc_o),
        .exc_delayslot_o    (exc_delayslot_o),
        .flush_o            (flush_o),
        .stall_o            (stall_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .redirect_ready_i   (redirect_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Scoreboard monitor: every exc_o pulse must match the oldest queued entry
    always @(negedge clk) begin
        exp_t e;
        if (exc_o !== 32'h0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL exc_unexpected: got exc_o=%h pc=%h, required no report", exc_o, exc_pc_o);
            end else begin
                e = sb.pop_front();
                if (exc_o !== e.code || exc_pc_o !== e.pc || exc_delayslot_o !== e.ds) begin
                    n_fail++;
                    $display("FAIL exc_report: got code=%h pc=%h ds=%b, required code=%h pc=%h ds=%b",
                             exc_o, exc_pc_o, exc_delayslot_o, e.code, e.pc, e.ds);
                end
            end
        end else begin
            n_tests++;
            if (exc_pc_o !== 32'h0 || exc_delayslot_o !== 1'b0) begin
                n_fail++;
                $display("FAIL exc_idle_fields: got pc=%h ds=%b, required 0/0", exc_pc_o, exc_delayslot_o);
            end
        end
        if (redirect_valid_o !== 1'b1) begin
            n_tests++;
            if (redirect_pc_o !== 32'h0) begin
                n_fail++;
                $display("FAIL redirect_pc_idle: got %h, required 0", redirect_pc_o);
            end
        end
    end

    task automatic clear_in();
        mem_valid_i        = 1'b0;
        mem_pc_i           = 32'h0;
        mem_in_delayslot_i = 1'b0;
        mem_syscall_i      = 1'b0;
        mem_ri_i           = 1'b0;
        mem_eret_i         = 1'b0;
        cp0_status_i       = 32'h0;
        cp0_cause_i        = 32'h0;
        cp0_epc_i          = 32'h0;
    endtask

    task automatic test_reset();
        clear_in();
        redirect_ready_i = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({exc_o, exc_pc_o, exc_delayslot_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got exc=%h flush=%b stall=%b rv=%b rpc=%h, required all 0",
                     exc_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got flush=%b stall=%b, required 0/0", flush_o, stall_o);
        end
        #2 rst = 1'b1;
    endtask

    // syscall at 0x100: report, two flush cycles, redirect to the vector
    task automatic test_syscall();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h100; mem_syscall_i = 1'b1;
        sb.push_back('{code: 32'h08, pc: 32'h100, ds: 1'b0});
        @(negedge clk);
        clear_in();
        n_tests++;
        if (flush_o !== 1'b1 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL syscall_flush1: got flush=%b stall=%b, required 1/1", flush_o, stall_o);
        end
        @(negedge clk);
        n_tests++;
        if (flush_o !== 1'b1 || exc_o !== 32'h0 || redirect_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL syscall_flush2: got flush=%b exc=%h rv=%b, required 1/0/0", flush_o, exc_o, redirect_valid_o);
        end
        @(negedge clk);
        n_tests++;
        if (flush_o !== 1'b0 || redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h20 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL syscall_redirect: got flush=%b rv=%b rpc=%h stall=%b, required 0/1/00000020/1",
                     flush_o, redirect_valid_o, redirect_pc_o, stall_o);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
        n_tests++;
        if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL syscall_idle: got rv=%b stall=%b, required 0/0", redirect_valid_o, stall_o);
        end
    endtask

    // interrupt beats a simultaneous syscall; delay-slot flag carried through
    task automatic test_interrupt_priority();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h200; mem_in_delayslot_i = 1'b1; mem_syscall_i = 1'b1;
        cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
        sb.push_back('{code: 32'h01, pc: 32'h200, ds: 1'b1});
        @(negedge clk);
        clear_in();
        repeat (FC) @(negedge clk);
        n_tests++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h20) begin
            n_fail++;
            $display("FAIL irq_redirect: got rv=%b rpc=%h, required 1/00000020", redirect_valid_o, redirect_pc_o);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
    endtask

    // eret redirects to the EPC sampled at the event, with EXL set
    task automatic test_eret();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h300; mem_eret_i = 1'b1;
        cp0_status_i = 32'h0000_0002; cp0_epc_i = 32'h1234;
        sb.push_back('{code: 32'h0e, pc: 32'h300, ds: 1'b0});
        @(negedge clk);
        clear_in();
        cp0_epc_i = 32'hdead_0000;
        repeat (FC) @(negedge clk);
        n_tests++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h1234) begin
            n_fail++;
            $display("FAIL eret_redirect: got rv=%b rpc=%h, required 1/00001234", redirect_valid_o, redirect_pc_o);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
        cp0_epc_i = 32'h0;
    endtask

    // ready withheld: redirect held stable, new events during flush/redirect ignored
    task automatic test_redirect_hold();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h400; mem_syscall_i = 1'b1;
        sb.push_back('{code: 32'h08, pc: 32'h400, ds: 1'b0});
        @(negedge clk);
        mem_ri_i = 1'b1; mem_pc_i = 32'h404;
        repeat (FC) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mem_syscall_i = 1'b1; mem_pc_i = 32'h410 + 32'(i);
            n_tests++;
            if (redirect_valid_o !== 1'b1 || stall_o !== 1'b1 || redirect_pc_o !== 32'h20) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got rv=%b stall=%b rpc=%h, required 1/1/00000020",
                         i, redirect_valid_o, stall_o, redirect_pc_o);
            end
            @(negedge clk);
        end
        clear_in();
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
        n_tests++;
        if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got rv=%b stall=%b, required 0/0", redirect_valid_o, stall_o);
        end
    endtask

    // async reset mid-flush, then the first event after release is taken
    task automatic test_async_reset();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h500; mem_syscall_i = 1'b1;
        sb.push_back('{code: 32'h08, pc: 32'h500, ds: 1'b0});
        @(negedge clk);
        clear_in();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (flush_o !== 1'b0 || stall_o !== 1'b0 || exc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: got flush=%b stall=%b exc=%h, required 0/0/0", flush_o, stall_o, exc_o);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        mem_valid_i = 1'b1; mem_pc_i = 32'h600; mem_ri_i = 1'b1;
        sb.push_back('{code: 32'h0a, pc: 32'h600, ds: 1'b0});
        @(negedge clk);
        clear_in();
        n_tests++;
        if (flush_o !== 1'b1 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_first_event: got flush=%b stall=%b, required 1/1", flush_o, stall_o);
        end
        repeat (FC) @(negedge clk);
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
    endtask

    // EXL blocks the interrupt; ri in the same cycle wins instead
    task automatic test_irq_masked();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h6f0;
        cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400;
        repeat (3) @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL exl_irq_blocked: got stall=%b, required 0", stall_o);
        end
        mem_ri_i = 1'b1; mem_pc_i = 32'h700;
        sb.push_back('{code: 32'h0a, pc: 32'h700, ds: 1'b0});
        @(negedge clk);
        clear_in();
        repeat (FC) @(negedge clk);
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
    endtask

    // flags without mem_valid_i never start an exception
    task automatic test_no_valid();
        @(negedge clk);
        mem_valid_i = 1'b0; mem_pc_i = 32'h780; mem_syscall_i = 1'b1; mem_ri_i = 1'b1; mem_eret_i = 1'b1;
        cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
        repeat (3) @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_valid: got stall=%b flush=%b, required 0/0", stall_o, flush_o);
        end
        clear_in();
    endtask

    // event held across the handshake: ignored in REDIRECT, taken right after
    task automatic test_back_to_back();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_pc_i = 32'h800; mem_syscall_i = 1'b1;
        sb.push_back('{code: 32'h08, pc: 32'h800, ds: 1'b0});
        @(negedge clk);
        clear_in();
        repeat (FC) @(negedge clk);
        redirect_ready_i = 1'b1;
        mem_valid_i = 1'b1; mem_pc_i = 32'h900; mem_in_delayslot_i = 1'b1; mem_syscall_i = 1'b1;
        sb.push_back('{code: 32'h08, pc: 32'h900, ds: 1'b1});
        @(negedge clk);
        redirect_ready_i = 1'b0;
        n_tests++;
        if (stall_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got stall=%b rv=%b, required 0/0", stall_o, redirect_valid_o);
        end
        @(negedge clk);
        clear_in();
        n_tests++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got flush=%b, required 1", flush_o);
        end
        repeat (FC) @(negedge clk);
        n_tests++;
        if (redirect_pc_o !== 32'h20) begin
            n_fail++;
            $display("FAIL b2b_redirect: got rpc=%h, required 00000020", redirect_pc_o);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_interrupt_priority();
        test_eret();
        test_redirect_hold();
        test_async_reset();
        test_irq_masked();
        test_no_valid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d reports outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion by 100000, required finish");
        $fatal(1, "timeout");
    end

endmodule
